button_press_classifier: RTL

//   Consumes the debounced rising/falling pulses from the edge detector stage.

---
 rtl/button_press_classifier.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/button_press_classifier.sv
//==============================================================================
// Module      : button_press_classifier
// Description : Turns debounced press/release pulses into one-cycle gesture
//               events: short press, double press, long press and, when
//               BUTTON_PRESS_CLASSIFIER_REPEAT_EN is defined, auto-repeat
//               pulses while the button stays long-held.
//               Configuration macro: BUTTON_PRESS_CLASSIFIER_REPEAT_EN
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module button_press_classifier #(
    parameter int LONG_COUNT    = 1000,
    parameter int DOUBLE_WINDOW = 250,
    parameter int REPEAT_COUNT  = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic rising,
    input  logic falling,
    output logic short_press,
    output logic double_press,
    output logic long_press,
    output logic repeat_press,
    output logic held
);

    // Shared counter sizing; the repeat period only matters when repeats exist.
    localparam int c_MAX_LW = (LONG_COUNT > DOUBLE_WINDOW) ? LONG_COUNT : DOUBLE_WINDOW;
`ifdef BUTTON_PRESS_CLASSIFIER_REPEAT_EN
    localparam int c_CNT_MAX = (c_MAX_LW > REPEAT_COUNT) ? c_MAX_LW : REPEAT_COUNT;
`else
    localparam int c_CNT_MAX = c_MAX_LW;
`endif
    localparam int c_CNT_W = $clog2(c_CNT_MAX);

    localparam logic [c_CNT_W-1:0] c_LONG_TERM = c_CNT_W'(LONG_COUNT - 1);
    localparam logic [c_CNT_W-1:0] c_WIN_TERM  = c_CNT_W'(DOUBLE_WINDOW - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_TOP   = c_CNT_W'(c_CNT_MAX - 1);
`ifdef BUTTON_PRESS_CLASSIFIER_REPEAT_EN
    localparam logic [c_CNT_W-1:0] c_REP_TERM  = c_CNT_W'(REPEAT_COUNT - 1);
`endif

    localparam logic [1:0] c_IDLE        = 2'd0;
    localparam logic [1:0] c_PRESSED     = 2'd1;
    localparam logic [1:0] c_WAIT_DOUBLE = 2'd2;
    localparam logic [1:0] c_LONG_HELD   = 2'd3;

    // Elaboration-time sanity check on the timing parameters.
    generate
        if (LONG_COUNT < 2 || DOUBLE_WINDOW < 2 || REPEAT_COUNT < 2) begin : g_bad_params
            $error("button_press_classifier: LONG_COUNT, DOUBLE_WINDOW and REPEAT_COUNT must be >= 2");
        end
    endgenerate

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_second;
    logic               r_short;
    logic               r_double;
    logic               r_long;
    logic               r_held;

    logic [1:0]         w_state_nx;
    logic [c_CNT_W-1:0] w_cnt_nx;
    logic [c_CNT_W-1:0] w_cnt_inc;
    logic               w_second_nx;
    logic               w_short_nx;
    logic               w_double_nx;
    logic               w_long_nx;
    logic               w_rise;
    logic               w_fall;

    // Simultaneous press and release pulses cancel each other out.
    assign w_rise = rising & ~falling;
    assign w_fall = falling & ~rising;

    // Counter never wraps on its own; it stops at its largest value.
    assign w_cnt_inc = (r_cnt == c_CNT_TOP) ? r_cnt : r_cnt + 1'b1;

`ifdef BUTTON_PRESS_CLASSIFIER_REPEAT_EN
    logic r_repeat;
    logic w_repeat_nx;
`endif

    // Next-state, counter and next-cycle event decode.
    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_second_nx = r_second;
        w_short_nx  = 1'b0;
        w_double_nx = 1'b0;
        w_long_nx   = 1'b0;
`ifdef BUTTON_PRESS_CLASSIFIER_REPEAT_EN
        w_repeat_nx = 1'b0;
`endif
        case (r_state)
            c_IDLE: begin
                if (w_rise) begin
                    w_state_nx  = c_PRESSED;
                    w_cnt_nx    = '0;
                    w_second_nx = 1'b0;
                end
            end
            c_PRESSED: begin
                // Reaching the long-hold threshold beats a release in the same cycle.
                if (r_cnt == c_LONG_TERM) begin
                    w_state_nx = c_LONG_HELD;
                    w_cnt_nx   = '0;
                    w_long_nx  = 1'b1;
                end else if (w_fall) begin
                    w_cnt_nx = '0;
                    if (r_second) begin
                        w_state_nx  = c_IDLE;
                        w_double_nx = 1'b1;
                    end else begin
                        w_state_nx = c_WAIT_DOUBLE;
                    end
                end else begin
                    w_cnt_nx = w_cnt_inc;
                end
            end
            c_WAIT_DOUBLE: begin
                // A new press wins over the window expiring in the same cycle.
                if (w_rise) begin
                    w_state_nx  = c_PRESSED;
                    w_cnt_nx    = '0;
                    w_second_nx = 1'b1;
                end else if (r_cnt == c_WIN_TERM) begin
                    w_state_nx = c_IDLE;
                    w_cnt_nx   = '0;
                    w_short_nx = 1'b1;
                end else begin
                    w_cnt_nx = w_cnt_inc;
                end
            end
            c_LONG_HELD: begin
                if (w_fall) begin
                    w_state_nx = c_IDLE;
                    w_cnt_nx   = '0;
                end
`ifdef BUTTON_PRESS_CLASSIFIER_REPEAT_EN
                // The long_press cycle is a settle cycle: repeat timing starts after it.
                else if (r_long) begin
                    w_cnt_nx = '0;
                end else if (r_cnt == c_REP_TERM) begin
                    w_cnt_nx    = '0;
                    w_repeat_nx = 1'b1;
                end else begin
                    w_cnt_nx = w_cnt_inc;
                end
`endif
            end
            default: begin
                w_state_nx = c_IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_second <= 1'b0;
            r_short  <= 1'b0;
            r_double <= 1'b0;
            r_long   <= 1'b0;
            r_held   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_second <= w_second_nx;
            r_short  <= w_short_nx;
            r_double <= w_double_nx;
            r_long   <= w_long_nx;
            r_held   <= (w_state_nx == c_PRESSED) || (w_state_nx == c_LONG_HELD);
        end
    end

`ifdef BUTTON_PRESS_CLASSIFIER_REPEAT_EN
    // Auto-repeat pulse register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_repeat <= 1'b0;
        end else begin
            r_repeat <= w_repeat_nx;
        end
    end

    assign repeat_press = r_repeat;
`else
    assign repeat_press = 1'b0;
`endif

    assign short_press  = r_short;
    assign double_press = r_double;
    assign long_press   = r_long;
    assign held         = r_held;

endmodule

`default_nettype wire
